fetch_pc_stage: RTL and testbench

FETCH_PC_STAGE -- requirements
Module: fetch_pc_stage

---
 rtl/fetch_pc_stage.sv | 112 +++++++++++
 tb/tb_fetch_pc_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_stage.sv
// Fetch PC stage: owns the program counter, the IF/ID register and a one-entry
// hold buffer. Optional macro FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap.
module fetch_pc_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_stall,
    input  logic [31:0] mem_instr,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] fetch_address,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        misalign_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] hold_buf, hold_buf_nxt;
    if_id_t      if_id, if_id_nxt;
    logic        err, err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            hold_buf <= 32'h0;
            if_id    <= '{valid: 1'b0, pc: 32'h0, instr: NOP};
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            hold_buf <= hold_buf_nxt;
            if_id    <= if_id_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        hold_buf_nxt = hold_buf;
        if_id_nxt    = if_id;
        err_nxt      = err;

        if (redirect_valid) begin
            // Redirect wins: flush IF/ID, drop buffered or returned instruction.
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_target[1:0] != 2'b00)
                err_nxt = 1'b1;
            else
                pc_nxt = redirect_target;
`else
            pc_nxt = redirect_target & ~32'h3;
`endif
            if_id_nxt.valid = 1'b0;
            hold_buf_nxt    = 32'h0;
            state_nxt       = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (!mem_stall) begin
                        if (!id_stall) begin
                            if_id_nxt = '{valid: 1'b1, pc: pc, instr: mem_instr};
                            pc_nxt    = pc + 32'd4;
                        end else begin
                            hold_buf_nxt = mem_instr;
                            state_nxt    = HOLD;
                        end
                    end else if (!id_stall) begin
                        if_id_nxt.valid = 1'b0;
                    end
                end
                HOLD: begin
                    // Fetch interface is ignored here; only decode release matters.
                    if (!id_stall) begin
                        if_id_nxt = '{valid: 1'b1, pc: pc, instr: hold_buf};
                        pc_nxt    = pc + 32'd4;
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    assign fetch_address = pc;
    assign if_id_valid   = if_id.valid;
    assign if_id_pc      = if_id.pc;
    assign if_id_instr   = if_id.instr;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_err = err;
`else
    // Trap disabled: the sticky register stays at zero and is not exported.
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Self-checking bench for fetch_pc_stage: reset checks, directed vector table,
// async reset in HOLD, and randomized traffic against a queue-based model.
module tb_fetch_pc_stage;

    localparam logic [31:0] RPC = 32'h100;
    localparam logic [31:0] NOP = 32'h13;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_stall;
    logic [31:0] mem_instr;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] fetch_address;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        misalign_err;

    int tests = 0;
    int fails = 0;

    fetch_pc_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .mem_stall(mem_stall), .mem_instr(mem_instr),
        .id_stall(id_stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .fetch_address(fetch_address),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ms;
        logic        ids;
        logic        rv;
        logic [31:0] ins;
        logic [31:0] tgt;
        logic [31:0] fa;
        logic        v;
        logic [31:0] ipc;
        logic [31:0] iins;
        logic        err;
    } vec_t;

    vec_t vecs[17];

    // Model state: hold buffer occupancy expressed as a queue.
    logic [31:0] m_pc, m_ipc, m_ins;
    logic        m_v, m_err;
    logic [31:0] m_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] fa, input logic v,
                           input logic [31:0] ipc, input logic [31:0] iins, input logic err);
        chk({tag, ".fetch_address"}, fetch_address, fa);
        chk({tag, ".if_id_valid"}, {31'h0, if_id_valid}, {31'h0, v});
        if (v) begin
            chk({tag, ".if_id_pc"}, if_id_pc, ipc);
            chk({tag, ".if_id_instr"}, if_id_instr, iins);
        end
        chk({tag, ".misalign_err"}, {31'h0, misalign_err}, {31'h0, err});
    endtask

    task automatic drive(input logic ms, input logic ids, input logic rv,
                         input logic [31:0] ins, input logic [31:0] tgt);
        mem_stall = ms; id_stall = ids; redirect_valid = rv;
        mem_instr = ins; redirect_target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        #2;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_pc = RPC; m_v = 1'b0; m_ipc = 32'h0; m_ins = NOP; m_err = 1'b0;
        m_q.delete();
    endtask

    function automatic vec_t mk(logic ms, logic ids, logic rv, logic [31:0] ins, logic [31:0] tgt,
                                logic [31:0] fa, logic v, logic [31:0] ipc, logic [31:0] iins,
                                logic err);
        vec_t r;
        r.ms = ms; r.ids = ids; r.rv = rv; r.ins = ins; r.tgt = tgt;
        r.fa = fa; r.v = v; r.ipc = ipc; r.iins = iins; r.err = err;
        return r;
    endfunction

    // Reference step: state HOLD is "the queue holds an instruction".
    task automatic model_step(input logic ms, input logic ids, input logic rv,
                              input logic [31:0] ins, input logic [31:0] tgt);
        if (rv) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (tgt % 4 != 0) m_err = 1'b1;
            else m_pc = tgt;
`else
            m_pc = tgt - (tgt % 4);
`endif
            m_v = 1'b0;
            m_q.delete();
        end else if (m_q.size() == 0) begin
            if (!ms && !ids) begin
                m_v = 1'b1; m_ipc = m_pc; m_ins = ins; m_pc = m_pc + 4;
            end else if (!ms) begin
                m_q.push_back(ins);
            end else if (!ids) begin
                m_v = 1'b0;
            end
        end else if (!ids) begin
            m_v = 1'b1; m_ipc = m_pc; m_ins = m_q.pop_front(); m_pc = m_pc + 4;
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_stall = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0;
        mem_instr = 32'h0; redirect_target = 32'h0;
        #2;
        // Values while reset is held.
        chk("rst.fetch_address", fetch_address, RPC);
        chk("rst.if_id_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst.if_id_pc", if_id_pc, 32'h0);
        chk("rst.if_id_instr", if_id_instr, NOP);
        chk("rst.misalign_err", {31'h0, misalign_err}, 32'h0);
        do_reset();

        //            ms   ids  rv   ins           tgt           fa            v    ipc           iins          err
        vecs[0]  = mk(0,   0,   0,   32'hA,        32'h0,        32'h104,      1,   32'h100,      32'hA,        0);
        vecs[1]  = mk(0,   1,   0,   32'hB,        32'h0,        32'h104,      1,   32'h100,      32'hA,        0);
        vecs[2]  = mk(1,   1,   0,   32'h0,        32'h0,        32'h104,      1,   32'h100,      32'hA,        0);
        vecs[3]  = mk(0,   1,   0,   32'hC,        32'h0,        32'h104,      1,   32'h100,      32'hA,        0);
        vecs[4]  = mk(1,   0,   0,   32'h0,        32'h0,        32'h108,      1,   32'h104,      32'hB,        0);
        vecs[5]  = mk(0,   1,   0,   32'hD,        32'h0,        32'h108,      1,   32'h104,      32'hB,        0);
        vecs[6]  = mk(1,   1,   1,   32'h0,        32'h200,      32'h200,      0,   32'h0,        32'h0,        0);
        vecs[7]  = mk(0,   0,   0,   32'hE,        32'h0,        32'h204,      1,   32'h200,      32'hE,        0);
        vecs[8]  = mk(0,   0,   1,   32'hF,        32'h300,      32'h300,      0,   32'h0,        32'h0,        0);
        vecs[9]  = mk(1,   0,   0,   32'h0,        32'h0,        32'h300,      0,   32'h0,        32'h0,        0);
        vecs[10] = mk(0,   0,   0,   32'h11,       32'h0,        32'h304,      1,   32'h300,      32'h11,       0);
        vecs[11] = mk(1,   1,   0,   32'h0,        32'h0,        32'h304,      1,   32'h300,      32'h11,       0);
        vecs[12] = mk(1,   0,   0,   32'h0,        32'h0,        32'h304,      0,   32'h0,        32'h0,        0);
        vecs[13] = mk(1,   0,   1,   32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 0,   32'h0,        32'h0,        0);
        vecs[14] = mk(0,   0,   0,   32'h22,       32'h0,        32'h0,        1,   32'hFFFFFFFC, 32'h22,       0);
`ifdef FETCH_MISALIGN_TRAP_EN
        vecs[15] = mk(1,   0,   1,   32'h0,        32'h202,      32'h0,        0,   32'h0,        32'h0,        1);
        vecs[16] = mk(0,   0,   0,   32'h33,       32'h0,        32'h4,        1,   32'h0,        32'h33,       1);
`else
        vecs[15] = mk(1,   0,   1,   32'h0,        32'h202,      32'h200,      0,   32'h0,        32'h0,        0);
        vecs[16] = mk(0,   0,   0,   32'h33,       32'h0,        32'h204,      1,   32'h200,      32'h33,       0);
`endif
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].ms, vecs[i].ids, vecs[i].rv, vecs[i].ins, vecs[i].tgt);
            chk_all($sformatf("vec%0d", i), vecs[i].fa, vecs[i].v, vecs[i].ipc, vecs[i].iins,
                    vecs[i].err);
        end
        // In HOLD with IF/ID valid, the held if_id_instr must not be the buffered word.
        do_reset();
        drive(0, 0, 0, 32'h55, 32'h0);
        drive(0, 1, 0, 32'h66, 32'h0);
        drive(1, 1, 1, 32'h0, 32'h400);
        chk("flush.if_id_instr_held", if_id_instr, 32'h55);
        drive(1, 0, 0, 32'h0, 32'h0);
        chk_all("flush.no_buf", 32'h400, 1'b0, 32'h0, 32'h0, 1'b0);

        // Asynchronous reset while in HOLD, then first edge from the reset state.
        do_reset();
        drive(0, 0, 0, 32'h77, 32'h0);
        drive(0, 1, 0, 32'h44, 32'h0);
        chk_all("hold.pre", 32'h104, 1'b1, 32'h100, 32'h77, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst.fetch_address", fetch_address, RPC);
        chk("arst.if_id_valid", {31'h0, if_id_valid}, 32'h0);
        chk("arst.if_id_pc", if_id_pc, 32'h0);
        chk("arst.if_id_instr", if_id_instr, NOP);
        #2;
        rst = 1'b0;
        drive(1, 0, 0, 32'h0, 32'h0);
        chk_all("arst.post1", RPC, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(0, 0, 0, 32'h99, 32'h0);
        chk_all("arst.post2", 32'h104, 1'b1, 32'h100, 32'h99, 1'b0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        ms, ids, rv;
            logic [31:0] ins, tgt;
            ms  = ($urandom_range(0, 2) == 0);
            ids = ($urandom_range(0, 2) == 0);
            rv  = ($urandom_range(0, 11) == 0);
            ins = $urandom;
            tgt = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 49) == 0) tgt = 32'hFFFF_FFFC;
            model_step(ms, ids, rv, ins, tgt);
            drive(ms, ids, rv, ins, tgt);
            chk_all($sformatf("rnd%0d", n), m_pc, m_v, m_ipc, m_ins, m_err);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
